// File: rtl/regfile_req_pkg.sv
// Shared types for the regfile request adapter: request type encoding, message structs
// and the response queue depth. Struct widths follow the REGFILE_REQ_* width macros.
`ifndef REGFILE_REQ_DATA_NBITS
`define REGFILE_REQ_DATA_NBITS 32
`endif
`ifndef REGFILE_REQ_ADDR_NBITS
`define REGFILE_REQ_ADDR_NBITS 5
`endif

package regfile_req_pkg;

  typedef enum logic {
    RF_REQ_READ  = 1'b0,
    RF_REQ_WRITE = 1'b1
  } rf_req_type_t;

  typedef struct packed {
    rf_req_type_t                       typ;
    logic [`REGFILE_REQ_ADDR_NBITS-1:0] addr;
    logic [`REGFILE_REQ_DATA_NBITS-1:0] data;
  } rf_req_msg_t;

  typedef struct packed {
    rf_req_type_t                       typ;
    logic [`REGFILE_REQ_DATA_NBITS-1:0] data;
  } rf_resp_msg_t;

  localparam int RESP_QUEUE_DEPTH = 2;

endpackage

// File: rtl/regfile_req_adapter_respq.sv
// Two-entry circular response queue: 1-bit enq/deq pointers and a 2-bit occupancy count.
// The producer never enqueues into a full queue, so enq_val carries no ready.
module regfile_req_adapter_respq
  import regfile_req_pkg::*;
#(
  parameter int p_data_nbits = 32
)
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enq_val,
  input  logic                    enq_type,
  input  logic [p_data_nbits-1:0] enq_data,
  output logic                    deq_val,
  input  logic                    deq_rdy,
  output logic                    deq_type,
  output logic [p_data_nbits-1:0] deq_data,
  output logic [1:0]              count
);

  logic                    r_type [RESP_QUEUE_DEPTH];
  logic [p_data_nbits-1:0] r_data [RESP_QUEUE_DEPTH];
  logic                    r_enq_ptr;
  logic                    r_deq_ptr;
  logic [1:0]              r_count;
  logic                    w_deq_xfer;

  assign deq_val    = (r_count != 2'd0);
  assign w_deq_xfer = deq_val && deq_rdy;
  assign deq_type   = r_type[r_deq_ptr];
  assign deq_data   = r_data[r_deq_ptr];
  assign count      = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_enq_ptr <= 1'b0;
      r_deq_ptr <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (enq_val)
        r_enq_ptr <= ~r_enq_ptr;
      if (w_deq_xfer)
        r_deq_ptr <= ~r_deq_ptr;
      // Simultaneous enq and deq leaves the occupancy unchanged.
      case ({enq_val, w_deq_xfer})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq_val) begin
      r_type[r_enq_ptr] <= enq_type;
      r_data[r_enq_ptr] <= enq_data;
    end
  end

endmodule

// File: rtl/regfile_req_adapter.sv
// Val/rdy request front end for a 1r1w regfile: one ACCESS stage, then a 2-entry response queue.
// Optional REGFILE_REQ_ADAPTER_ZERO_EN makes entry 0 read as zero and ignore writes.
module regfile_req_adapter
  import regfile_req_pkg::*;
#(
  parameter  int p_data_nbits  = 32,
  parameter  int p_num_entries = 32,
  localparam int c_addr_nbits  = $clog2(p_num_entries)
)
(
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    req_val,
  output logic                    req_rdy,
  input  logic                    req_type,
  input  logic [c_addr_nbits-1:0] req_addr,
  input  logic [p_data_nbits-1:0] req_data,

  output logic                    resp_val,
  input  logic                    resp_rdy,
  output logic                    resp_type,
  output logic [p_data_nbits-1:0] resp_data,

  output logic [c_addr_nbits-1:0] rf_read_addr,
  input  logic [p_data_nbits-1:0] rf_read_data,
  output logic                    rf_write_en,
  output logic [c_addr_nbits-1:0] rf_write_addr,
  output logic [p_data_nbits-1:0] rf_write_data
);

  logic                    w_req_xfer;
  logic                    r_acc_val_p1;
  rf_req_type_t            r_acc_type_p1;
  logic [c_addr_nbits-1:0] r_acc_addr_p1;
  logic [p_data_nbits-1:0] r_acc_data_p1;
  logic                    w_acc_is_wr_p1;
  logic                    w_wen_p1;
  logic [p_data_nbits-1:0] w_rd_data_p1;
  logic [p_data_nbits-1:0] w_resp_data_p1;
  logic [1:0]              w_resp_count;

  // Credits count queued responses plus the one in ACCESS, so the queue can never overflow.
  assign req_rdy    = ({1'b0, w_resp_count} + {2'b00, r_acc_val_p1}) < 3'd2;
  assign w_req_xfer = req_val && req_rdy;

  // ---- accept edge -> ACCESS stage ----
  always_ff @(posedge clk) begin
    if (reset)
      r_acc_val_p1 <= 1'b0;
    else
      r_acc_val_p1 <= w_req_xfer;
  end

  always_ff @(posedge clk) begin
    if (w_req_xfer) begin
      r_acc_type_p1 <= rf_req_type_t'(req_type);
      r_acc_addr_p1 <= req_addr;
      r_acc_data_p1 <= req_data;
    end
  end

  assign w_acc_is_wr_p1 = (r_acc_type_p1 == RF_REQ_WRITE);

`ifdef REGFILE_REQ_ADAPTER_ZERO_EN
  logic w_addr_zero_p1;
  assign w_addr_zero_p1 = (r_acc_addr_p1 == '0);
  assign w_wen_p1       = r_acc_val_p1 && w_acc_is_wr_p1 && !w_addr_zero_p1;
  assign w_rd_data_p1   = w_addr_zero_p1 ? '0 : rf_read_data;
`else
  assign w_wen_p1       = r_acc_val_p1 && w_acc_is_wr_p1;
  assign w_rd_data_p1   = rf_read_data;
`endif

  // Write addr/data only change on accept, so they hold their last value while idle.
  assign rf_read_addr   = r_acc_addr_p1;
  assign rf_write_en    = w_wen_p1;
  assign rf_write_addr  = r_acc_addr_p1;
  assign rf_write_data  = r_acc_data_p1;
  assign w_resp_data_p1 = w_acc_is_wr_p1 ? '0 : w_rd_data_p1;

  // ---- ACCESS -> response queue ----
  regfile_req_adapter_respq #(
    .p_data_nbits (p_data_nbits)
  ) u_respq (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (r_acc_val_p1),
    .enq_type (w_acc_is_wr_p1),
    .enq_data (w_resp_data_p1),
    .deq_val  (resp_val),
    .deq_rdy  (resp_rdy),
    .deq_type (resp_type),
    .deq_data (resp_data),
    .count    (w_resp_count)
  );

endmodule

// File: tb/tb_regfile_req_adapter.sv
// Scoreboard bench for regfile_req_adapter: a regfile model behind the rf_* ports, an
// in-order reference memory that predicts responses at accept time, and a negedge monitor.
module tb_regfile_req_adapter;

  localparam int DW = 32;
  localparam int NE = 32;
  localparam int AW = 5;
`ifdef REGFILE_REQ_ADAPTER_ZERO_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_val = 1'b0;
  logic          req_rdy;
  logic          req_type = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          resp_val;
  logic          resp_rdy = 1'b1;
  logic          resp_type;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] rf_read_addr;
  logic [DW-1:0] rf_read_data;
  logic          rf_write_en;
  logic [AW-1:0] rf_write_addr;
  logic [DW-1:0] rf_write_data;

  regfile_req_adapter #(.p_data_nbits(DW), .p_num_entries(NE)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_type(req_type),
    .req_addr(req_addr), .req_data(req_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_type(resp_type), .resp_data(resp_data),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Regfile instance model: combinational read, clocked write, never reset.
  logic [DW-1:0] rf_mem [NE];
  assign rf_read_data = rf_mem[rf_read_addr];
  initial begin
    for (int i = 0; i < NE; i++) rf_mem[i] = 32'h1000_0000 + i * 7;
    forever begin
      @(posedge clk);
      if (rf_write_en === 1'b1) rf_mem[rf_write_addr] <= rf_write_data;
    end
  end

  typedef struct {
    logic          typ;
    logic [DW-1:0] data;
    int            acc_edge;
    bit            chk_lat;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] ref_mem [NE];
  int            checks = 0;
  int            failures = 0;
  bit            chk_on = 0;
  int            wen_edge = -1;
  bit            wen_exp = 0;
  int            n_acc = 0;
  bit            rnd_done = 0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, req, $time);
    end
  endfunction

  // Monitor: rf_write_en must be high exactly in the ACCESS cycle of an effective write;
  // each dequeued response is compared with the head of the scoreboard.
  exp_t mon_e;
  always @(negedge clk) begin
    if (chk_on) begin
      check("rf_write_en", rf_write_en, (cyc == wen_edge) ? wen_exp : 1'b0);
      if (resp_val === 1'b1 && resp_rdy) begin
        if (sbq.size() == 0) begin
          check("resp_without_request", resp_val, 1'b0);
        end else begin
          mon_e = sbq.pop_front();
          check("resp_type", resp_type, mon_e.typ);
          check("resp_data", resp_data, mon_e.data);
          if (mon_e.chk_lat) check("resp_latency_cycles", cyc - mon_e.acc_edge + 1, 2);
        end
      end
    end
  end

  task automatic send(input logic t, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit lat);
    int   w = 0;
    exp_t e;
    req_val = 1'b1; req_type = t; req_addr = a; req_data = d;
    forever begin
      @(negedge clk); #1;
      if (req_rdy === 1'b1) break;
      w++;
      if (w > 200) begin
        check("req_accept_timeout", req_rdy, 1'b1);
        break;
      end
    end
    if (req_rdy === 1'b1) begin
      e.typ = t; e.acc_edge = cyc + 1; e.chk_lat = lat;
      if (t) begin
        e.data = '0;
        if (!(ZERO && a == 0)) ref_mem[a] = d;
      end else begin
        e.data = (ZERO && a == 0) ? '0 : ref_mem[a];
      end
      sbq.push_back(e);
      wen_edge = cyc + 1;
      wen_exp  = t && !(ZERO && a == 0);
      n_acc++;
    end
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("drain_scoreboard_empty", sbq.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NE; i++) ref_mem[i] = 32'h1000_0000 + i * 7;

    // 1: reset state, held and released
    repeat (2) @(posedge clk);
    #1 chk_on = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_req_rdy", req_rdy, 1'b1);
      check("rst_resp_val", resp_val, 1'b0);
    end
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_req_rdy", req_rdy, 1'b1);
      check("idle_resp_val", resp_val, 1'b0);
    end
    @(posedge clk); #1;

    // 2: write then read same address
    send(1'b1, 5, 32'hdeadbeef, 1);
    send(1'b0, 5, '0, 1);
    drain();

    // 3: back-to-back 8 writes then 8 reads
    for (int i = 0; i < 8; i++) send(1'b1, AW'(i + 8), DW'(i * 3), 1);
    for (int i = 0; i < 8; i++) send(1'b0, AW'(i + 8), '0, 1);
    drain();

    // 4: backpressure, only two credits
    resp_rdy = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(1'b0, AW'(20 + i), '0, 0);
      end
      begin
        @(negedge clk); #2 check("bp_rdy_c1", req_rdy, 1'b1);
        @(negedge clk); #2 check("bp_rdy_c2", req_rdy, 1'b1);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk); #2 check("bp_rdy_stalled", req_rdy, 1'b0);
        end
        check("bp_accepted", n_acc, 2);
        @(posedge clk); #1 resp_rdy = 1'b1;
      end
    join
    drain();

    // 5: entry 0
    send(1'b1, 0, 32'h1234, 1);
    send(1'b0, 0, '0, 1);
    drain();

    // 6: reset mid-operation with a response queued and a read in ACCESS
    resp_rdy = 1'b0;
    send(1'b1, 7, 32'hcafe_f00d, 0);
    send(1'b0, 3, '0, 0);
    check("pre_reset_resp_val", resp_val, 1'b1);
    reset = 1'b1;
    sbq.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_resp_val", resp_val, 1'b0);
    check("post_reset_req_rdy", req_rdy, 1'b1);
    @(posedge clk); #1 resp_rdy = 1'b1;
    send(1'b0, 7, '0, 1);
    drain();

    // Randomized traffic with random response backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(1'($urandom_range(0, 1)), AW'($urandom_range(0, NE - 1)), $urandom, 0);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          resp_rdy = ($urandom_range(0, 3) != 0);
        end
      end
    join
    resp_rdy = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
